// File: rtl/rsp_seq_ctrl.sv
// Command/response transaction sequencer: tracks one command from accept through
// response arming, response timeout supervision and completion with error status.
module rsp_seq_ctrl #(
    parameter int unsigned ListenDelay = 2,
    parameter int unsigned NcrMax      = 64
) (
    input  logic       sd_clk_i,
    input  logic       rst_ni,
    input  logic       cmd_start_i,
    input  logic [5:0] cmd_index_i,
    input  logic [1:0] rsp_type_i,
    input  logic       chk_crc_i,
    input  logic       chk_idx_i,
    input  logic       abort_i,
    input  logic       cmd_tx_done_i,
    input  logic       rsp_valid_i,
    input  logic       rsp_crc_corr_i,
    input  logic       rsp_end_bit_err_i,
    input  logic [5:0] rsp_index_i,
    output logic       long_rsp_o,
    output logic       start_listening_o,
    output logic       busy_o,
    output logic       cmd_complete_o,
    output logic       timeout_err_o,
    output logic       crc_err_o,
    output logic       end_bit_err_o,
    output logic       index_err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_TX = 3'd1,
        S_DELAY   = 3'd2,
        S_LISTEN  = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [7:0] LimShort     = 8'(NcrMax + 52);
    localparam logic [7:0] LimLong      = 8'(NcrMax + 140);
    localparam bit         DirectListen = (ListenDelay == 1);
    // DELAY state is entered one cycle after tx_done, so the arm decision lands one count early
    localparam logic [2:0] DelayLast    = (ListenDelay >= 2) ? 3'(ListenDelay - 2) : 3'd0;

    state_e     state_q, state_d;
    logic [2:0] dly_cnt_q, dly_cnt_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic [5:0] idx_q, idx_d;
    logic [1:0] type_q, type_d;
    logic       chk_crc_q, chk_crc_d;
    logic       chk_idx_q, chk_idx_d;
    logic       long_q, long_d;
    logic       listen_q, listen_d;
    logic       busy_q, busy_d;
    logic       complete_q, complete_d;
    logic       to_err_q, to_err_d;
    logic       crc_err_q, crc_err_d;
    logic       eb_err_q, eb_err_d;
    logic       idx_err_q, idx_err_d;
    logic [7:0] limit_s;

    assign limit_s = (type_q == 2'b10) ? LimLong : LimShort;

    // State register and registered outputs, synchronous active-low reset
    always_ff @(posedge sd_clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            dly_cnt_q  <= 3'd0;
            to_cnt_q   <= 8'd0;
            idx_q      <= 6'd0;
            type_q     <= 2'd0;
            chk_crc_q  <= 1'b0;
            chk_idx_q  <= 1'b0;
            long_q     <= 1'b0;
            listen_q   <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            to_err_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            eb_err_q   <= 1'b0;
            idx_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            to_cnt_q   <= to_cnt_d;
            idx_q      <= idx_d;
            type_q     <= type_d;
            chk_crc_q  <= chk_crc_d;
            chk_idx_q  <= chk_idx_d;
            long_q     <= long_d;
            listen_q   <= listen_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            to_err_q   <= to_err_d;
            crc_err_q  <= crc_err_d;
            eb_err_q   <= eb_err_d;
            idx_err_q  <= idx_err_d;
        end
    end

    // Next-state and next-output logic; pulses and error flags default low
    always_comb begin
        state_d    = state_q;
        dly_cnt_d  = dly_cnt_q;
        to_cnt_d   = to_cnt_q;
        idx_d      = idx_q;
        type_d     = type_q;
        chk_crc_d  = chk_crc_q;
        chk_idx_d  = chk_idx_q;
        long_d     = long_q;
        busy_d     = busy_q;
        listen_d   = 1'b0;
        complete_d = 1'b0;
        to_err_d   = 1'b0;
        crc_err_d  = 1'b0;
        eb_err_d   = 1'b0;
        idx_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start_i) begin
                    state_d   = S_WAIT_TX;
                    idx_d     = cmd_index_i;
                    type_d    = rsp_type_i;
                    chk_crc_d = chk_crc_i;
                    chk_idx_d = chk_idx_i;
                    busy_d    = 1'b1;
                    long_d    = (rsp_type_i == 2'b10);
                end else begin
                    busy_d = 1'b0;
                    long_d = 1'b0;
                end
            end
            S_WAIT_TX: begin
                if (!cmd_tx_done_i) begin
                    state_d = S_WAIT_TX;
                end else if (type_q == 2'b00) begin
                    state_d    = S_DONE;
                    complete_d = 1'b1;
                end else if (DirectListen) begin
                    state_d  = S_LISTEN;
                    listen_d = 1'b1;
                    to_cnt_d = 8'd1;
                end else begin
                    state_d   = S_DELAY;
                    dly_cnt_d = 3'd0;
                end
            end
            S_DELAY: begin
                if (dly_cnt_q == DelayLast) begin
                    state_d  = S_LISTEN;
                    listen_d = 1'b1;
                    to_cnt_d = 8'd1;
                end else begin
                    dly_cnt_d = dly_cnt_q + 3'd1;
                end
            end
            S_LISTEN: begin
                // to_cnt_q counts LISTEN cycles including the current one; a response beats the limit
                if (rsp_valid_i) begin
                    state_d    = S_DONE;
                    complete_d = 1'b1;
                    crc_err_d  = chk_crc_q & ~rsp_crc_corr_i;
                    eb_err_d   = rsp_end_bit_err_i;
                    idx_err_d  = chk_idx_q & (rsp_index_i != idx_q);
                end else if (to_cnt_q == limit_s) begin
                    state_d    = S_DONE;
                    complete_d = 1'b1;
                    to_err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                long_d    = 1'b0;
                dly_cnt_d = 3'd0;
                to_cnt_d  = 8'd0;
            end
            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                long_d    = 1'b0;
                dly_cnt_d = 3'd0;
                to_cnt_d  = 8'd0;
            end
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            long_d     = 1'b0;
            listen_d   = 1'b0;
            complete_d = 1'b0;
            to_err_d   = 1'b0;
            crc_err_d  = 1'b0;
            eb_err_d   = 1'b0;
            idx_err_d  = 1'b0;
            dly_cnt_d  = 3'd0;
            to_cnt_d   = 8'd0;
        end else begin
            state_d = state_d;
        end
    end

    assign long_rsp_o        = long_q;
    assign start_listening_o = listen_q;
    assign busy_o            = busy_q;
    assign cmd_complete_o    = complete_q;
    assign timeout_err_o     = to_err_q;
    assign crc_err_o         = crc_err_q;
    assign end_bit_err_o     = eb_err_q;
    assign index_err_o       = idx_err_q;

endmodule
